// File: rtl/sample_packetizer_if.sv
// ---------------------------------------------------------------------------
// sample_packetizer_if
// AXI-Stream style bundle carrying 16-bit packet words out of the sample
// packetizer towards the 16-to-8 width adapter.
//   m_tdata  : 16-bit word
//   m_tvalid : word valid
//   m_tready : downstream ready
//   m_tlast  : final word of a packet
// The master modport is the packetizer side, the slave modport the consumer.
// ---------------------------------------------------------------------------
interface sample_packetizer_if;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/sample_packetizer.sv
// ---------------------------------------------------------------------------
// sample_packetizer
// Buffers ADC samples in a small FIFO and emits them as packets: one header
// word followed by PACKET_SAMPLES payload words {pkt_seq[3:0], sample}.
// Samples arriving while the FIFO is full are dropped and counted.
//
// Ports
//   clk          : single clock, rising edge
//   rst          : synchronous active-high reset
//   sample_valid : one-cycle strobe for sample_data
//   sample_data  : SAMPLE_WIDTH-bit sample
//   m_axis       : packet stream (sample_packetizer_if master)
//   overflow     : sticky, set on any dropped sample
//   drop_count   : dropped sample count, saturates at 255
//
// State     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no packet in flight, FIFO empty, m_tvalid low
// ST_HEADER | presenting HEADER_WORD
// ST_PAYLOAD| presenting FIFO head; waits (tvalid low) if FIFO runs dry
// ---------------------------------------------------------------------------
module sample_packetizer #(
    parameter int          SAMPLE_WIDTH   = 12,
    parameter int          PACKET_SAMPLES = 4,
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [15:0] HEADER_WORD    = 16'hA55A
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic [SAMPLE_WIDTH-1:0] sample_data,
    sample_packetizer_if.master     m_axis,
    output logic                    overflow,
    output logic [7:0]              drop_count
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]             wr_ptr_q, rd_ptr_q;
    logic [AW:0]             count;
    logic                    full, empty, wr_en, pop, xfer;
    logic                    nonempty_next, last_word;

    logic [1:0] state_q, state_d;
    logic [7:0] word_cnt_q, word_cnt_d;
    logic [3:0] pkt_seq_q, pkt_seq_d;
    logic       overflow_q;
    logic [7:0] drop_cnt_q;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    // Full FIFO drops the sample even if a pop happens in the same cycle.
    assign wr_en = sample_valid && !full;
    assign xfer  = m_axis.m_tvalid && m_axis.m_tready;
    assign pop   = (state_q == ST_PAYLOAD) && xfer;
    // Occupancy after this edge is non-zero.
    assign nonempty_next = wr_en || (count > {{AW{1'b0}}, pop});
    assign last_word     = (word_cnt_q == 8'(PACKET_SAMPLES - 1));

    always_comb begin
        m_axis.m_tvalid = 1'b0;
        m_axis.m_tdata  = {pkt_seq_q, 12'(mem_q[rd_ptr_q[AW-1:0]])};
        m_axis.m_tlast  = 1'b0;
        case (state_q)
            ST_HEADER: begin
                m_axis.m_tvalid = 1'b1;
                m_axis.m_tdata  = HEADER_WORD;
            end
            ST_PAYLOAD: begin
                m_axis.m_tvalid = !empty;
                m_axis.m_tlast  = !empty && last_word;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        pkt_seq_d  = pkt_seq_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty || wr_en) state_d = ST_HEADER;
            end
            ST_HEADER: begin
                if (xfer) begin
                    word_cnt_d = '0;
                    state_d    = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (pop) begin
                    if (last_word) begin
                        pkt_seq_d  = pkt_seq_q + 4'd1;
                        word_cnt_d = '0;
                        state_d    = nonempty_next ? ST_HEADER : ST_IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            pkt_seq_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            pkt_seq_q  <= pkt_seq_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (sample_valid && full) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wr_ptr_q[AW-1:0]] <= sample_data;
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_sample_packetizer.sv
module tb_sample_packetizer;
    localparam int PS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] sample_data = '0;
    logic        overflow;
    logic [7:0]  drop_count;

    sample_packetizer_if ax ();

    sample_packetizer #(
        .SAMPLE_WIDTH(12), .PACKET_SAMPLES(PS), .FIFO_DEPTH(8), .HEADER_WORD(16'hA55A)
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .m_axis(ax), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    logic [16:0] sb [$];
    int          m_idx = 0;
    logic [3:0]  m_seq = '0;
    bit          rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) ax.m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic model_push(input logic [11:0] d);
        if (m_idx == 0) sb.push_back({1'b0, 16'hA55A});
        sb.push_back({(m_idx == PS-1), m_seq, d});
        m_idx++;
        if (m_idx == PS) begin
            m_idx = 0;
            m_seq = m_seq + 4'd1;
        end
    endtask

    task automatic send(input logic [11:0] d, input bit accept);
        sample_valid = 1'b1;
        sample_data  = d;
        if (accept) model_push(d);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        sb.delete();
        m_idx = 0;
        m_seq = '0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    // Output monitor: compares each transferred word with the scoreboard and
    // checks that a stalled word is held.
    bit          stall = 1'b0;
    logic [16:0] held;
    logic [16:0] exp_w;
    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_tvalid", ax.m_tvalid, 1);
                chk("stall_word", {ax.m_tlast, ax.m_tdata}, held);
            end
            if (!ax.m_tvalid) chk("idle_tlast", ax.m_tlast, 0);
            if (ax.m_tvalid && ax.m_tready) begin
                chk("sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    exp_w = sb.pop_front();
                    chk("word", {ax.m_tlast, ax.m_tdata}, exp_w);
                end
            end
            stall = ax.m_tvalid && !ax.m_tready;
            held  = {ax.m_tlast, ax.m_tdata};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ax.m_tready = 1'b1;
        // Reset, with samples presented during reset
        rst = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 12'h3C3;
        repeat (3) tick();
        sample_valid = 1'b0;
        rst = 1'b0;
        chk("rst_tvalid", ax.m_tvalid, 0);
        chk("rst_tlast", ax.m_tlast, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_count, 0);
        tick();
        chk("rst_discard_tvalid", ax.m_tvalid, 0);

        // Basic packet + header latency
        send(12'h123, 1);
        chk("hdr_lat_tvalid", ax.m_tvalid, 1);
        chk("hdr_lat_tdata", ax.m_tdata, 16'hA55A);
        send(12'h456, 1);
        send(12'h789, 1);
        send(12'hABC, 1);
        drain(50);

        // Sequence wrap over 17 packets
        do_reset();
        for (int p = 0; p < 17; p++) begin
            for (int k = 0; k < PS; k++) send(12'(12'h100 + p*4 + k), 1);
            tick();
        end
        drain(200);

        // Random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(12'($urandom_range(0, 4095)), 1);
            repeat (4) tick();
        end
        drain(1000);
        rand_rdy = 1'b0;
        ax.m_tready = 1'b1;

        // Overflow and saturation
        do_reset();
        ax.m_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(12'(12'h200 + i), (i < 8));
            if (i == 7) begin
                chk("pre_ovf_flag", overflow, 0);
                chk("pre_ovf_drop", drop_count, 0);
            end
        end
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop2", drop_count, 2);
        for (int i = 0; i < 300; i++) send(12'hFFF, 0);
        chk("ovf_drop_sat", drop_count, 255);
        chk("ovf_sticky", overflow, 1);
        ax.m_tready = 1'b1;
        drain(100);

        // Starved packet
        do_reset();
        send(12'h011, 1);
        send(12'h022, 1);
        repeat (3) tick();
        for (int i = 0; i < 17; i++) begin
            chk("gap_tvalid", ax.m_tvalid, 0);
            tick();
        end
        send(12'h033, 1);
        send(12'h044, 1);
        drain(50);

        // Reset mid-packet
        ax.m_tready = 1'b0;
        for (int i = 0; i < PS; i++) send(12'(12'h700 + i), 1);
        ax.m_tready = 1'b1;
        tick();
        tick();
        ax.m_tready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tvalid", ax.m_tvalid, 0);
        chk("midrst_tlast", ax.m_tlast, 0);
        chk("midrst_words_sent", sb.size(), 3);
        sb.delete();
        m_idx = 0;
        m_seq = '0;
        ax.m_tready = 1'b1;
        tick();
        chk("midrst_empty", ax.m_tvalid, 0);
        send(12'h811, 1);
        chk("midrst_hdr", ax.m_tdata, 16'hA55A);
        send(12'h822, 1);
        send(12'h833, 1);
        send(12'h844, 1);
        drain(50);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/sample_packetizer.md
SAMPLE_PACKETIZER -- requirements
Module: sample_packetizer

Interface
REQ-001 The module SHALL have parameter SAMPLE_WIDTH, default 12, the ADC sample width in bits; legal range 1..12.
REQ-002 The module SHALL have parameter PACKET_SAMPLES, default 4, the number of sample words per packet; legal range 1..255.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 8, the sample buffer depth; it SHALL be a power of two, >= 2.
REQ-004 The module SHALL have parameter HEADER_WORD, default 16'hA55A, the first word of every packet.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; one clock domain, all logic on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port sample_valid, input, 1 bit: a one-cycle strobe marking sample_data as a new sample.
REQ-008 The module SHALL have port sample_data, input, SAMPLE_WIDTH bits: the sample value.
REQ-009 The module SHALL have port m_tdata, output, 16 bits: the AXI-Stream data to the 16-to-8 width adapter.
REQ-010 The module SHALL have port m_tvalid, output, 1 bit: the AXI-Stream valid.
REQ-011 The module SHALL have port m_tready, input, 1 bit: the AXI-Stream ready.
REQ-012 The module SHALL have port m_tlast, output, 1 bit: marks the final word of a packet.
REQ-013 The module SHALL have port overflow, output, 1 bit: sticky flag, set when a sample is dropped.
REQ-014 The module SHALL have port drop_count, output, 8 bits: the number of dropped samples, saturating at 255.

Function
REQ-015 Write rule: a sample SHALL be written to the FIFO on a rising edge where sample_valid=1 and FIFO occupancy is below FIFO_DEPTH at the start of that cycle.
REQ-016 Dropping: sample_valid=1 while the FIFO is full SHALL drop the sample, set overflow=1, and increment drop_count by 1, holding at 255.
REQ-017 Full FIFO: a read in the same cycle SHALL NOT make room for the dropped sample.
REQ-018 Simultaneous read and write: when the FIFO is not full, a read and write in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-019 Transfer rule: a word SHALL transfer only on a rising edge with m_tvalid=1 and m_tready=1.
REQ-020 Output stability: while m_tvalid=1 and m_tready=0, m_tdata and m_tlast SHALL hold stable.
REQ-021 Combinational paths: m_tvalid SHALL NOT depend combinationally on m_tready.
REQ-022 The FSM SHALL have the states IDLE, HEADER and PAYLOAD.
REQ-023 IDLE: m_tvalid=0; the FSM SHALL go to HEADER on the edge after which the FIFO is non-empty.
REQ-024 HEADER: m_tvalid=1, m_tdata=HEADER_WORD, m_tlast=0; on transfer the FSM SHALL clear the word counter and go to PAYLOAD.
REQ-025 PAYLOAD: m_tvalid SHALL equal FIFO non-empty.
REQ-026 PAYLOAD data: m_tdata SHALL be {pkt_seq[3:0], FIFO head zero-extended to 12 bits}.
REQ-027 PAYLOAD tlast: m_tlast=1 exactly when word counter = PACKET_SAMPLES-1.
REQ-028 PAYLOAD transfer: each transfer SHALL pop the FIFO and increment the word counter.
REQ-029 End of packet: on the transfer with m_tlast=1, the FSM SHALL increment pkt_seq (4-bit, wraps 15->0) and go to HEADER if the FIFO is non-empty after the pop, else to IDLE.
REQ-030 FIFO empty mid-packet: the FSM SHALL stay in PAYLOAD with m_tvalid=0; packets SHALL never be truncated or padded.
REQ-031 Latency: the header SHALL be valid on the cycle after the first sample write from IDLE.
REQ-032 Throughput: with m_tready held at 1, a packet SHALL take PACKET_SAMPLES+1 consecutive cycles once enough samples are buffered.

Reset
REQ-033 Reset values: while rst=1 at a rising edge, the FSM SHALL go to IDLE and the FIFO SHALL empty; pkt_seq, word counter, drop_count and overflow SHALL be 0; m_tvalid=0.
REQ-034 Reset mid-packet SHALL abandon the packet with no tlast emitted.
REQ-035 Samples presented while rst=1 SHALL be discarded and not counted as drops.
REQ-036 Output values with m_tvalid=0 are don't-care, except that m_tlast SHALL be 0.

Verification
REQ-037 Basic packet: 4 samples 0x123, 0x456, 0x789, 0xABC with m_tready=1 -> A55A, 0123, 0456, 0789, 0ABC, with tlast on 0ABC.
REQ-038 Sequence wrap: 17 back-to-back packets -> the payload upper nibble steps 0..15 then 0.
REQ-039 Backpressure: m_tready toggling pseudo-randomly -> identical word sequence; tdata stable across every stall.
REQ-040 Overflow: 10 samples on consecutive cycles with m_tready=0 -> 8 kept, overflow=1, drop_count=2; 300 excess samples -> drop_count=255.
REQ-041 Starved packet: 2 samples, then a 20-cycle gap, then 2 samples -> one packet with tvalid low during the gap and tlast on the 4th sample.
REQ-042 Reset mid-packet: rst after the header plus 1 payload word -> m_tvalid=0 next cycle; the next packet starts with A55A and sequence 0.
